// File: rtl/led_frame_buffer.sv
// rtl/led_frame_buffer.sv - double-banked 8x16 RGB frame buffer with vsync-aligned bank swap
// The back bank takes pixel writes and row clears; the front bank feeds the LED driver.
module led_frame_buffer (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   row,
  input  logic         vsync,
  output logic [383:0] values,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [2:0]   wr_row,
  input  logic [3:0]   wr_col,
  input  logic [23:0]  wr_data,
  input  logic         swap_req,
  input  logic         clr_req,
  output logic         swap_done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  state_t         state;
  state_t         state_next;
  logic           front_sel;
  logic [2:0]     clr_cnt;
  logic           wr_fire;
  logic           swap_fire;
  logic [8:0]     col_lsb;

  // Entries 0-7 are bank 0 and entries 8-15 are bank 1, addressed as {bank, row}.
  logic [383:0]   mem [16];

  always_comb begin
    state_next = state;
    swap_fire  = 1'b0;
    case (state)
      IDLE: begin
        if (clr_req)       state_next = CLEAR;
        else if (swap_req) state_next = PENDING;
      end
      PENDING: begin
        if (vsync) begin
          state_next = IDLE;
          swap_fire  = 1'b1;
        end
      end
      CLEAR: begin
        if (clr_cnt == 3'd7) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign wr_fire  = wr_valid & wr_ready;
  // 24*col built as 16*col + 8*col.
  assign col_lsb  = {2'b00, wr_col, 3'b000} + {1'b0, wr_col, 4'b0000};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      front_sel <= 1'b0;
      clr_cnt   <= 3'd0;
      swap_done <= 1'b0;
    end else begin
      state     <= state_next;
      swap_done <= swap_fire;
      if (swap_fire) front_sel <= ~front_sel;
      if (state == IDLE && clr_req) clr_cnt <= 3'd0;
      else if (state == CLEAR)      clr_cnt <= clr_cnt + 3'd1;
    end
  end

  // Writes only happen in IDLE and clears only in CLEAR, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
    end else if (wr_fire) begin
      mem[{~front_sel, wr_row}][col_lsb +: 24] <= wr_data;
    end else if (state == CLEAR) begin
      mem[{~front_sel, clr_cnt}] <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) values <= '0;
    else      values <= mem[{front_sel, row}];
  end

endmodule
